// File: rtl/wb_wcombine.sv
// Wishbone wide-bus write combiner: merges back-to-back single-lane writes to the
// same wide word into one downstream write, one ack per accepted upstream request.
module wb_wcombine #(
    parameter int ADDRESS_WIDTH = 28,
    parameter int DW            = 512,
    parameter int LGMERGE       = 3,
    parameter int LGTIMEOUT     = 4,
    parameter bit OPT_LOWPOWER  = 1'b0,
    localparam int AW           = ADDRESS_WIDTH - $clog2(DW/8)
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sstall,
    output logic            o_sack,
    output logic [DW-1:0]   o_sdata,
    output logic            o_serr,
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic [DW-1:0]   i_mdata
);

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ISSUE, S_WAIT, S_RETURN} state_t;

    localparam logic [LGMERGE:0] MAX_MERGE = {1'b1, {LGMERGE{1'b0}}};
    localparam logic [LGMERGE:0] ONE       = {{LGMERGE{1'b0}}, 1'b1};

    state_t               state;
    logic [LGMERGE:0]     nmerge;
    logic [LGMERGE:0]     ack_cnt;
    logic [LGTIMEOUT-1:0] timeout;
    logic                 merge_ok;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_d,
                                                  input logic [DW-1:0] new_d,
                                                  input logic [DW/8-1:0] sel);
        logic [DW-1:0] r;
        for (int b = 0; b < DW/8; b++)
            r[b*8 +: 8] = sel[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
        return r;
    endfunction

    // A merge is decided in the same cycle the request is presented
    assign merge_ok = (state == S_HOLD) && i_sstb && i_swe
                      && (i_saddr == o_maddr) && (nmerge < MAX_MERGE);

    always_comb begin
        o_sstall = 1'b1;
        case (state)
            S_IDLE:  o_sstall = 1'b0;
            S_HOLD:  o_sstall = !merge_ok;
            default: o_sstall = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            nmerge  <= '0;
            ack_cnt <= '0;
            timeout <= '0;
            o_sack  <= 1'b0;
            o_sdata <= '0;
            o_serr  <= 1'b0;
            o_mcyc  <= 1'b0;
            o_mstb  <= 1'b0;
            o_mwe   <= 1'b0;
            o_maddr <= '0;
            o_mdata <= '0;
            o_msel  <= '0;
        end else begin
            o_serr <= 1'b0;
            if (!i_scyc) begin
                // Abort takes priority over everything, including a same-cycle ack
                state   <= S_IDLE;
                nmerge  <= '0;
                ack_cnt <= '0;
                timeout <= '0;
                o_sack  <= 1'b0;
                o_mcyc  <= 1'b0;
                o_mstb  <= 1'b0;
                if (OPT_LOWPOWER) begin
                    o_sdata <= '0;
                    o_maddr <= '0;
                    o_mdata <= '0;
                    o_msel  <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: if (i_sstb) begin
                        o_maddr <= i_saddr;
                        o_mwe   <= i_swe;
                        o_msel  <= i_ssel;
                        nmerge  <= ONE;
                        timeout <= '0;
                        o_mcyc  <= 1'b1;
                        if (OPT_LOWPOWER)
                            o_sdata <= '0;
                        if (i_swe) begin
                            o_mdata <= merge_bytes('0, i_sdata, i_ssel);
                            state   <= S_HOLD;
                        end else begin
                            if (OPT_LOWPOWER)
                                o_mdata <= '0;
                            o_mstb <= 1'b1;
                            state  <= S_ISSUE;
                        end
                    end
                    S_HOLD: begin
                        if (merge_ok) begin
                            o_mdata <= merge_bytes(o_mdata, i_sdata, i_ssel);
                            o_msel  <= o_msel | i_ssel;
                            nmerge  <= nmerge + 1'b1;
                            timeout <= '0;
                        end else if (i_sstb || (&timeout)) begin
                            o_mstb  <= 1'b1;
                            timeout <= '0;
                            state   <= S_ISSUE;
                        end else begin
                            timeout <= timeout + 1'b1;
                        end
                    end
                    S_ISSUE, S_WAIT: begin
                        if (i_merr) begin
                            // Error wins over ack; the merged requests get no acks
                            o_serr <= 1'b1;
                            o_mcyc <= 1'b0;
                            o_mstb <= 1'b0;
                            nmerge <= '0;
                            state  <= S_IDLE;
                            if (OPT_LOWPOWER) begin
                                o_maddr <= '0;
                                o_mdata <= '0;
                                o_msel  <= '0;
                            end
                        end else if (state == S_ISSUE) begin
                            if (!i_mstall) begin
                                o_mstb <= 1'b0;
                                state  <= S_WAIT;
                            end
                        end else if (i_mack) begin
                            o_mcyc  <= 1'b0;
                            o_sack  <= 1'b1;
                            ack_cnt <= nmerge;
                            if (!o_mwe)
                                o_sdata <= i_mdata;
                            state   <= S_RETURN;
                        end
                    end
                    S_RETURN: begin
                        if (ack_cnt == ONE) begin
                            o_sack  <= 1'b0;
                            ack_cnt <= '0;
                            nmerge  <= '0;
                            state   <= S_IDLE;
                            if (OPT_LOWPOWER) begin
                                o_sdata <= '0;
                                o_maddr <= '0;
                                o_mdata <= '0;
                                o_msel  <= '0;
                            end
                        end else begin
                            ack_cnt <= ack_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_wcombine.sv
// Self-checking bench for wb_wcombine: directed scenarios plus randomized write/read
// streams compared against a transaction-level merge model.
module tb_wb_wcombine;

    localparam int ADDRESS_WIDTH = 28;
    localparam int DW            = 512;
    localparam int SW            = DW/8;
    localparam int AW            = ADDRESS_WIDTH - $clog2(SW);
    localparam int LGMERGE       = 3;
    localparam int LGTIMEOUT     = 4;
    localparam int MAXN          = 1 << LGMERGE;
    localparam int TMO           = 1 << LGTIMEOUT;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_scyc = 1'b0;
    logic          i_sstb = 1'b0;
    logic          i_swe = 1'b0;
    logic [AW-1:0] i_saddr = '0;
    logic [DW-1:0] i_sdata = '0;
    logic [SW-1:0] i_ssel = '0;
    logic          o_sstall, o_sack, o_serr, o_mcyc, o_mstb, o_mwe;
    logic [DW-1:0] o_sdata, o_mdata;
    logic [AW-1:0] o_maddr;
    logic [SW-1:0] o_msel;
    logic          i_mstall = 1'b0;
    logic          i_mack = 1'b0;
    logic          i_merr = 1'b0;
    logic [DW-1:0] i_mdata = '0;

    wb_wcombine #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH), .DW(DW), .LGMERGE(LGMERGE),
        .LGTIMEOUT(LGTIMEOUT), .OPT_LOWPOWER(1'b0)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
        .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
        .o_sstall(o_sstall), .o_sack(o_sack), .o_sdata(o_sdata), .o_serr(o_serr),
        .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
        .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
        .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        int            n;
    } xact_t;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    xact_t         req_q[$];
    xact_t         got_q[$];
    logic [DW-1:0] rdata_q[$];
    int            runs_q[$];
    logic [DW-1:0] run_data_q[$];
    int            sack_cyc_q[$];
    int            serr_cnt = 0;
    logic          mcyc_at_serr = 1'b1;
    int            ack_cyc = 0;
    int            acc_cyc = 0;
    int            ack_delay = 1;
    bit            err_mode = 1'b0;

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SW-1:0] rand_sel();
        logic [SW-1:0] r;
        for (int i = 0; i < SW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Downstream slave: acks (or errors) ack_delay cycles after an accepted strobe.
    // The strobe's n field holds the cycle it was seen.
    int cd = 0;
    always begin
        xact_t t;
        @(posedge i_clk);
        #1;
        i_mack = 1'b0;
        i_merr = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (err_mode) begin
                    i_merr = 1'b1;
                end else begin
                    i_mack  = 1'b1;
                    i_mdata = rand_wide();
                    rdata_q.push_back(i_mdata);
                    ack_cyc = cyc;
                end
            end
        end
        if (o_mcyc && o_mstb && !i_mstall) begin
            t.we = o_mwe; t.addr = o_maddr; t.data = o_mdata; t.sel = o_msel; t.n = cyc;
            got_q.push_back(t);
            cd = ack_delay;
        end
    end

    // Upstream monitor: lengths of consecutive ack runs and error pulses
    int run = 0;
    always @(negedge i_clk) begin
        if (o_sack) begin
            if (run == 0) begin
                run_data_q.push_back(o_sdata);
                sack_cyc_q.push_back(cyc);
            end
            run++;
        end else if (run > 0) begin
            runs_q.push_back(run);
            run = 0;
        end
        if (o_serr) begin
            serr_cnt++;
            mcyc_at_serr = o_mcyc;
        end
    end

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_q.delete(); got_q.delete(); rdata_q.delete(); runs_q.delete();
        run_data_q.delete(); sack_cyc_q.delete();
        serr_cnt = 0;
        mcyc_at_serr = 1'b1;
    endtask

    // Present one request (called just after a rising edge); returns stall cycles
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int waited);
        xact_t r;
        i_sstb = 1'b1; i_swe = we; i_saddr = a; i_sdata = d; i_ssel = s;
        waited = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (!o_sstall) begin
                waited = k;
                acc_cyc = cyc;
                break;
            end
        end
        if (waited >= 0) begin
            r.we = we; r.addr = a; r.data = d; r.sel = s; r.n = 1;
            req_q.push_back(r);
        end else begin
            chk_i("accept_timeout", waited, 0);
        end
        @(posedge i_clk);
        #1;
        i_sstb = 1'b0;
        i_swe  = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk_w({tag, "_ctl"}, DW'({o_sstall, o_mcyc, o_mstb, o_mwe, o_sack, o_serr}), '0);
        chk_w({tag, "_sdata"}, o_sdata, '0);
        chk_w({tag, "_maddr"}, DW'(o_maddr), '0);
        chk_w({tag, "_mdata"}, o_mdata, '0);
        chk_w({tag, "_msel"}, DW'(o_msel), '0);
    endtask

    // Model: consecutive writes to one word combine (up to MAXN), unselected bytes 0;
    // anything else closes the open group; each read is its own transaction.
    task automatic check_model(input string tag);
        xact_t e_q[$];
        xact_t cur;
        bit    open = 1'b0;
        foreach (req_q[i]) begin
            xact_t r = req_q[i];
            if (r.we && open && r.addr == cur.addr && cur.n < MAXN) begin
                for (int b = 0; b < SW; b++)
                    if (r.sel[b]) cur.data[b*8 +: 8] = r.data[b*8 +: 8];
                cur.sel = cur.sel | r.sel;
                cur.n++;
            end else begin
                if (open) e_q.push_back(cur);
                open = 1'b0;
                cur = r;
                cur.n = 1;
                if (r.we) begin
                    cur.data = '0;
                    for (int b = 0; b < SW; b++)
                        if (r.sel[b]) cur.data[b*8 +: 8] = r.data[b*8 +: 8];
                    open = 1'b1;
                end else begin
                    e_q.push_back(cur);
                end
            end
        end
        if (open) e_q.push_back(cur);
        chk_i({tag, "_ntxn"}, got_q.size(), e_q.size());
        chk_i({tag, "_nruns"}, runs_q.size(), e_q.size());
        for (int i = 0; i < e_q.size() && i < got_q.size(); i++) begin
            chk_w({tag, "_addr"}, DW'({got_q[i].we, got_q[i].addr}), DW'({e_q[i].we, e_q[i].addr}));
            if (e_q[i].we) begin
                chk_w({tag, "_data"}, got_q[i].data, e_q[i].data);
                chk_w({tag, "_sel"}, DW'(got_q[i].sel), DW'(e_q[i].sel));
            end else if (i < run_data_q.size() && i < rdata_q.size()) begin
                chk_w({tag, "_rdata"}, run_data_q[i], rdata_q[i]);
            end
            if (i < runs_q.size()) chk_i({tag, "_acks"}, runs_q[i], e_q[i].n);
        end
    endtask

    initial begin
        int w, w9, acc_w, acc_r;
        logic [AW-1:0] a, b;

        // Reset
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk_idle_outputs("reset");
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        i_scyc = 1'b1;
        idle(2);

        // Single write: hold timeout, strobe, ack latency
        clear_logs();
        ack_delay = 2;
        send(1'b1, AW'('h5), rand_wide(), rand_sel(), w);
        acc_w = acc_cyc;
        idle(40);
        if (got_q.size() > 0) chk_i("single_strobe_cycle", got_q[0].n - acc_w, TMO + 1);
        if (sack_cyc_q.size() > 0) chk_i("single_sack_cycle", sack_cyc_q[0], ack_cyc + 1);
        check_model("single");

        // Four nibble-lane writes to 0x10 combine into one
        clear_logs();
        ack_delay = 1;
        for (int i = 0; i < 4; i++)
            send(1'b1, AW'('h10), rand_wide(), SW'(64'hF << (4*i)), w);
        idle(40);
        if (got_q.size() > 0) chk_w("four_sel", DW'(got_q[0].sel), DW'(64'hFFFF));
        check_model("four");

        // Nine writes to 0x20: the ninth stalls and starts a new hold
        clear_logs();
        w9 = 0;
        for (int i = 0; i < 9; i++) begin
            send(1'b1, AW'('h20), rand_wide(), rand_sel(), w);
            if (i == 8) w9 = w;
        end
        chk_i("ninth_stalled", int'(w9 > 0), 1);
        idle(50);
        check_model("nine");

        // Write then read: read forces an early flush
        clear_logs();
        ack_delay = 3;
        send(1'b1, AW'('h30), rand_wide(), rand_sel(), w);
        acc_w = acc_cyc;
        send(1'b0, AW'('h40), '0, {SW{1'b1}}, w);
        acc_r = acc_cyc;
        idle(20);
        if (got_q.size() > 1) begin
            chk_i("early_flush_cycle", got_q[0].n - acc_w, 2);
            chk_i("read_strobe_cycle", got_q[1].n - acc_r, 1);
        end
        if (sack_cyc_q.size() > 1) chk_i("read_sack_cycle", sack_cyc_q[1], ack_cyc + 1);
        check_model("wr_rd");

        // Downstream error after three merged writes
        clear_logs();
        ack_delay = 2;
        err_mode = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1'b1, AW'('h50), rand_wide(), rand_sel(), w);
        idle(40);
        err_mode = 1'b0;
        chk_i("err_pulses", serr_cnt, 1);
        chk_i("err_mcyc_after", int'(mcyc_at_serr), 0);
        chk_i("err_acks", runs_q.size(), 0);
        chk_i("err_strobes", got_q.size(), 1);

        // Abort in HOLD with two merged writes
        clear_logs();
        send(1'b1, AW'('h60), rand_wide(), rand_sel(), w);
        send(1'b1, AW'('h60), rand_wide(), rand_sel(), w);
        @(negedge i_clk);
        chk_i("abort_pre_mcyc", int'(o_mcyc), 1);
        @(posedge i_clk);
        #1;
        i_scyc = 1'b0;
        @(posedge i_clk);
        #1;
        i_scyc = 1'b1;
        @(negedge i_clk);
        chk_i("abort_mcyc", int'(o_mcyc), 0);
        chk_i("abort_sstall", int'(o_sstall), 0);
        idle(40);
        chk_i("abort_strobes", got_q.size(), 0);
        chk_i("abort_acks", runs_q.size(), 0);

        // Reset while holding a write
        clear_logs();
        send(1'b1, AW'('h70), rand_wide(), rand_sel(), w);
        idle(3);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk_idle_outputs("midhold_reset");
        idle(40);
        chk_i("midhold_reset_strobes", got_q.size(), 0);

        // Randomized streams over two word addresses
        for (int round = 0; round < 6; round++) begin
            int nreq;
            clear_logs();
            ack_delay = $urandom_range(1, 3);
            nreq = $urandom_range(3, 12);
            a = AW'($urandom);
            b = a ^ AW'(1);
            for (int i = 0; i < nreq; i++)
                send($urandom_range(0, 4) != 0, ($urandom_range(0, 1) != 0) ? a : b,
                     rand_wide(), rand_sel(), w);
            idle(60);
            check_model("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
